// File: rtl/seq_checker.sv
// Player-side checker for the sequence memory game: regenerates the LFSR
// sequence from the captured seed and scores each guess against it.
module seq_checker #(
   parameter int unsigned SYM_W     = 2,
   parameter int unsigned ROUND_W   = 5,
   parameter int unsigned MAX_ROUND = 31
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [9:0]         seed,
   input  logic               start,
   input  logic               guess_valid,
   input  logic [SYM_W-1:0]   guess,
   input  logic               next_round,
   output logic [SYM_W-1:0]   expected,
   output logic [ROUND_W-1:0] idx,
   output logic [ROUND_W-1:0] round,
   output logic               busy,
   output logic               round_pass,
   output logic               game_fail,
   output logic               game_win
);

   localparam int unsigned LFSR_W = 10;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CHECK = 3'd1;
   localparam logic [2:0] S_PASS  = 3'd2;
   localparam logic [2:0] S_FAIL  = 3'd3;
   localparam logic [2:0] S_WIN   = 3'd4;

   logic [2:0]         state, state_nxt;
   logic [LFSR_W-1:0]  seed_reg, seed_nxt;
   logic [LFSR_W-1:0]  lfsr_cur, lfsr_nxt;
   logic [ROUND_W-1:0] idx_nxt, round_nxt;
   logic               guess_ok_c;
   logic               last_c;

   // Must stay bit-identical to the generator's step function.
   function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] x);
      return x ^ (x << 1) ^ (x << 5);
   endfunction

   // Bit 0 is invariant under the step, so symbols come from the top bits.
   assign expected   = lfsr_cur[LFSR_W-1 -: SYM_W];
   assign guess_ok_c = (guess == expected);
   assign last_c     = (idx == round - ROUND_W'(1));

   // Next-state and datapath update.
   always_comb begin
      state_nxt = state;
      seed_nxt  = seed_reg;
      lfsr_nxt  = lfsr_cur;
      idx_nxt   = idx;
      round_nxt = round;
      if (start) begin
         seed_nxt  = seed;
         lfsr_nxt  = seed;
         idx_nxt   = '0;
         round_nxt = ROUND_W'(1);
         state_nxt = S_CHECK;
      end else begin
         case (state)
            S_CHECK: begin
               if (guess_valid) begin
                  if (!guess_ok_c) begin
                     state_nxt = S_FAIL;
                  end else if (!last_c) begin
                     idx_nxt  = idx + ROUND_W'(1);
                     lfsr_nxt = lfsr_step(lfsr_cur);
                  end else if (round == ROUND_W'(MAX_ROUND)) begin
                     state_nxt = S_WIN;
                  end else begin
                     state_nxt = S_PASS;
                  end
               end
            end
            S_PASS: begin
               if (next_round) begin
                  round_nxt = round + ROUND_W'(1);
                  idx_nxt   = '0;
                  lfsr_nxt  = seed_reg;
                  state_nxt = S_CHECK;
               end
            end
            default: ;
         endcase
      end
   end

   // State, datapath and registered status decode.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= S_IDLE;
         seed_reg   <= '0;
         lfsr_cur   <= '0;
         idx        <= '0;
         round      <= '0;
         busy       <= 1'b0;
         round_pass <= 1'b0;
         game_fail  <= 1'b0;
         game_win   <= 1'b0;
      end else begin
         state      <= state_nxt;
         seed_reg   <= seed_nxt;
         lfsr_cur   <= lfsr_nxt;
         idx        <= idx_nxt;
         round      <= round_nxt;
         busy       <= (state_nxt == S_CHECK);
         round_pass <= (state_nxt == S_PASS);
         game_fail  <= (state_nxt == S_FAIL);
         game_win   <= (state_nxt == S_WIN);
      end
   end

endmodule

// File: doc/seq_checker.md
Name: seq_checker

Overview:
- Player-input side of the sequence memory game; counterpart to the 10-bit LFSR sequence generator.
- On start it captures the same 10-bit seed the generator was loaded with. It then regenerates the identical pseudo-random sequence internally.
- It compares each player guess against the expected symbol and tracks index, round, pass, fail and win for the game controller and display.
- Fully synchronous to clk: guesses arrive as single-cycle strobes, not as edges.

Parameters:
- SYM_W, 2: symbol width (2 bits = 4 buttons/colours).
- ROUND_W, 5: width of the round and index counters.
- MAX_ROUND, 31: the round whose completion wins the game; must be ≥1 and ≤ 2^ROUND_W-1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- seed  in  10  LFSR seed, sampled on start.
- start  in  1  1-cycle pulse: load seed, begin round 1.
- guess_valid  in  1  1-cycle strobe: guess is valid this cycle.
- guess  in  SYM_W  player's symbol.
- next_round  in  1  1-cycle pulse: advance from PASS to the next round.
- expected  out  SYM_W  symbol expected at the current idx.
- idx  out  ROUND_W  position within the current round, 0-based.
- round  out  ROUND_W  current round number (sequence length); 0 before the first start.
- busy  out  1  high in CHECK.
- round_pass  out  1  high while in PASS.
- game_fail  out  1  high while in FAIL.
- game_win  out  1  high while in WIN.

Behaviour:
- Step function: F(x) = (x ^ (x<<1) ^ (x<<5)) truncated to 10 bits. Element k = F^k(seed); element 0 = seed. This must be bit-identical to the generator.
- F preserves bit 0, so the symbol is taken from the high bits: expected = lfsr_cur[9:10-SYM_W].
- Seed 0 is legal and gives all-zero symbols.
- Registers: seed_reg, lfsr_cur, idx, round, state.
- All are cleared asynchronously on reset low: state=IDLE, everything else 0.
- Consequently all status outputs are 0 and expected=0 in reset.
- States are IDLE, CHECK, PASS, FAIL and WIN. Each status output is a registered decode of the state.
- start, from any state: seed_reg←seed, lfsr_cur←seed, idx←0, round←1, state←CHECK.
- start has priority over guess_valid and next_round in the same cycle.
- CHECK, guess_valid with guess==expected and idx<round-1: idx←idx+1, lfsr_cur←F(lfsr_cur). Stay in CHECK.
- CHECK, guess_valid with guess==expected and idx==round-1:
  - if round==MAX_ROUND, go to WIN;
  - otherwise go to PASS.
  - idx and lfsr_cur hold their values.
- CHECK, guess_valid with guess≠expected: go to FAIL. idx, round and lfsr_cur hold, so the failing position stays visible.
- PASS, next_round: round←round+1, idx←0, lfsr_cur←seed_reg, state←CHECK.
- Latency: the state and outputs reflect a guess one cycle after the strobe. A guess on every consecutive cycle is supported.
- Ignored inputs:
  - guess_valid is ignored in IDLE, PASS, FAIL and WIN.
  - next_round is ignored outside PASS.
  - FAIL and WIN leave only on start or reset.
- A change on the seed input is ignored except in a start cycle.
- Reset asserted mid-round aborts immediately to IDLE with all values cleared. There is no partial state.

Test Plan:
1. Reset, then start with seed=10'h3A5 → next cycle: busy=1, round=1, idx=0, expected=3. Guess 3 → round_pass=1 one cycle later.
2. Continue from 1: next_round, then guesses 3,0 → round_pass with round=2. Then next_round and guesses 3,0,1 → round_pass with round=3. This confirms lfsr 0x3A5→0x04F→0x131.
3. Round 2 of seed 0x3A5: guess 3 then guess 2 → game_fail=1, idx=1, expected=0. Later guess_valid pulses change nothing. start restores busy=1, round=1.
4. MAX_ROUND=2, seed 0x3A5: rounds 1 and 2 answered correctly → game_win=1 (round_pass stays 0). next_round and guesses are ignored.
5. Mid-round (idx=1): drive start with seed=10'h001 and guess_valid=1 in the same cycle → round=1, idx=0, expected=0, no fail.
6. Drop reset mid-round → all outputs 0 asynchronously, before the next clk edge.
7. guess_valid in IDLE or PASS → no state change.
